// File: rtl/speed_ctrl_if.sv
// Signal bundle between the CPU speed controller and its environment.
// The master side drives the button, software strobe and bus-idle; the slave side reports speed status.
interface speed_ctrl_if;
    logic turboSw;
    logic regWr;
    logic regSpeed;
    logic busIdle;
    logic speed;
    logic haltReq;
    logic busy;
    logic speedChg;
    logic timeout;

    modport master (
        output turboSw, regWr, regSpeed, busIdle,
        input  speed, haltReq, busy, speedChg, timeout
    );

    modport slave (
        input  turboSw, regWr, regSpeed, busIdle,
        output speed, haltReq, busy, speedChg, timeout
    );
endinterface

// File: rtl/speed_ctrl.sv
// CPU speed switch controller: drains the bus, flips SPEED, then holds the CPU while the clock settles.
// Define SPEED_CTRL_TURBO_SW_EN to include the synchronized, debounced front-panel turbo button.
module speed_ctrl #(
    parameter int DEBOUNCE_CYC  = 1000000,
    parameter int SETTLE_CYC    = 16,
    parameter int DRAIN_TIMEOUT = 4096
) (
    input logic          i_clk100m,
    input logic          i_reset,
    speed_ctrl_if.slave  io_bus
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int DRN_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_SWITCH,
        S_SETTLE
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic               r_speed;
    logic               r_halt;
    logic               r_chg;
    logic               r_timeout;
    logic               r_pending;
    logic               r_target;
    logic               r_idlePair;
    logic [DRN_W-1:0]   r_drainCnt;
    logic [SET_W-1:0]   r_settleCnt;

    logic               w_haltNext;
    logic               w_speedNext;
    logic               w_chgNext;
    logic               w_timeoutSet;
    logic               w_pendClr;
    logic               w_idlePairNext;
    logic [DRN_W-1:0]   w_drainCntNext;
    logic [SET_W-1:0]   w_settleCntNext;
    logic               w_btnRise;

`ifdef SPEED_CTRL_TURBO_SW_EN
    localparam int DEB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_debLevel;
    logic [DEB_W-1:0]   r_debCnt;

    // The level is accepted on the last of DEBOUNCE_CYC consecutive differing samples
    always_ff @(posedge i_clk100m) begin
        if (i_reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_debLevel <= 1'b0;
            r_debCnt   <= '0;
        end else begin
            r_sync1 <= io_bus.turboSw;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_debLevel) begin
                if (r_debCnt == DEB_LAST) begin
                    r_debLevel <= r_sync2;
                    r_debCnt   <= '0;
                end else begin
                    r_debCnt <= r_debCnt + DEB_W'(1);
                end
            end else begin
                r_debCnt <= '0;
            end
        end
    end

    assign w_btnRise = r_sync2 && !r_debLevel && (r_debCnt == DEB_LAST);
`else
    assign w_btnRise = 1'b0;
`endif

    always_comb begin
        w_stateNext     = r_state;
        w_haltNext      = r_halt;
        w_speedNext     = r_speed;
        w_chgNext       = 1'b0;
        w_timeoutSet    = 1'b0;
        w_pendClr       = 1'b0;
        w_idlePairNext  = r_idlePair;
        w_drainCntNext  = r_drainCnt;
        w_settleCntNext = r_settleCnt;
        case (r_state)
            S_IDLE: begin
                if (r_pending) begin
                    if (r_target != r_speed) begin
                        w_stateNext    = S_DRAIN;
                        w_haltNext     = 1'b1;
                        w_drainCntNext = '0;
                        w_idlePairNext = 1'b0;
                    end else begin
                        w_pendClr = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                // A completed idle pair beats a timeout landing on the same cycle
                if (io_bus.busIdle && r_idlePair) begin
                    w_stateNext = S_SWITCH;
                end else if (r_drainCnt == DRN_LAST) begin
                    w_stateNext  = S_IDLE;
                    w_haltNext   = 1'b0;
                    w_timeoutSet = 1'b1;
                    w_pendClr    = 1'b1;
                end else begin
                    w_drainCntNext = r_drainCnt + DRN_W'(1);
                    w_idlePairNext = io_bus.busIdle;
                end
            end
            S_SWITCH: begin
                w_speedNext     = r_target;
                w_chgNext       = (r_target != r_speed);
                w_pendClr       = 1'b1;
                w_stateNext     = S_SETTLE;
                w_settleCntNext = '0;
            end
            S_SETTLE: begin
                if (r_settleCnt == SET_LAST) begin
                    w_stateNext = S_IDLE;
                    w_haltNext  = 1'b0;
                end else begin
                    w_settleCntNext = r_settleCnt + SET_W'(1);
                end
            end
            default: begin
                w_stateNext = S_IDLE;
                w_haltNext  = 1'b0;
            end
        endcase
    end

    // New requests override any clear issued by the FSM in the same cycle
    always_ff @(posedge i_clk100m) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_speed     <= 1'b0;
            r_halt      <= 1'b0;
            r_chg       <= 1'b0;
            r_timeout   <= 1'b0;
            r_pending   <= 1'b0;
            r_target    <= 1'b0;
            r_idlePair  <= 1'b0;
            r_drainCnt  <= '0;
            r_settleCnt <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_speed     <= w_speedNext;
            r_halt      <= w_haltNext;
            r_chg       <= w_chgNext;
            r_idlePair  <= w_idlePairNext;
            r_drainCnt  <= w_drainCntNext;
            r_settleCnt <= w_settleCntNext;
            if (io_bus.regWr) begin
                r_target  <= io_bus.regSpeed;
                r_pending <= 1'b1;
            end else if (w_btnRise) begin
                r_target  <= ~r_target;
                r_pending <= 1'b1;
            end else if (w_pendClr) begin
                r_pending <= 1'b0;
            end
            if (w_timeoutSet) begin
                r_timeout <= 1'b1;
            end else if (io_bus.regWr) begin
                r_timeout <= 1'b0;
            end
        end
    end

    assign io_bus.speed    = r_speed;
    assign io_bus.haltReq  = r_halt;
    assign io_bus.busy     = (r_state != S_IDLE);
    assign io_bus.speedChg = r_chg;
    assign io_bus.timeout  = r_timeout;

endmodule

// File: tb/tb_speed_ctrl.sv
// Testbench for speed_ctrl: fixed vectors, hand-written corner sequences and a randomized run
// checked against a behavioural model of the switch sequence.
module tb_speed_ctrl;
    localparam int DEB = 8;
    localparam int SET = 4;
    localparam int DRN = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    speed_ctrl_if bus();

    speed_ctrl #(
        .DEBOUNCE_CYC (DEB),
        .SETTLE_CYC   (SET),
        .DRAIN_TIMEOUT(DRN)
    ) dut (
        .i_clk100m(clk),
        .i_reset  (rst),
        .io_bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: phase flags plus elapsed-cycle counts
    bit mSpeed, mHalt, mChg, mTimeout, mPending, mTarget;
    bit draining, switching, settling;
    int drainAge, idleRun, settleAge;
    bit s1, s2, level;
    bit hist[$];

    typedef struct {
        bit r; bit w; bit sp; bit idle;
        bit eSpeed; bit eHalt; bit eBusy; bit eChg; bit eTmo;
    } vec_t;

    task automatic modelReset();
        mSpeed = 0; mHalt = 0; mChg = 0; mTimeout = 0; mPending = 0; mTarget = 0;
        draining = 0; switching = 0; settling = 0;
        drainAge = 0; idleRun = 0; settleAge = 0;
        s1 = 0; s2 = 0; level = 0;
        hist.delete();
    endtask

    task automatic modelStep();
        bit rise;
        bit pTarget;
        bit pPending;
        bit clr;
        bit tset;
        bit allDiffer;
        rise = 0;
        clr = 0;
        tset = 0;
        if (rst) begin
            modelReset();
            return;
        end
`ifdef SPEED_CTRL_TURBO_SW_EN
        hist.push_back(s2);
        if (hist.size() > DEB) void'(hist.pop_front());
        if (hist.size() == DEB) begin
            allDiffer = 1;
            foreach (hist[i]) if (hist[i] == level) allDiffer = 0;
            if (allDiffer) begin
                rise  = !level;
                level = ~level;
            end
        end
        s2 = s1;
        s1 = bus.turboSw;
`else
        allDiffer = 0;
`endif
        pTarget  = mTarget;
        pPending = mPending;
        mChg = 0;
        if (draining) begin
            drainAge++;
            idleRun = bus.busIdle ? idleRun + 1 : 0;
            if (idleRun >= 2) begin
                draining  = 0;
                switching = 1;
            end else if (drainAge >= DRN) begin
                draining = 0;
                mHalt = 0;
                tset = 1;
                clr = 1;
            end
        end else if (switching) begin
            mChg = (pTarget != mSpeed);
            mSpeed = pTarget;
            clr = 1;
            switching = 0;
            settling = 1;
            settleAge = 0;
        end else if (settling) begin
            settleAge++;
            if (settleAge >= SET) begin
                settling = 0;
                mHalt = 0;
            end
        end else if (pPending) begin
            if (pTarget != mSpeed) begin
                draining = 1;
                drainAge = 0;
                idleRun = 0;
                mHalt = 1;
            end else begin
                clr = 1;
            end
        end
        if (bus.regWr) begin
            mTarget = bus.regSpeed;
            mPending = 1;
        end else if (rise) begin
            mTarget = ~pTarget;
            mPending = 1;
        end else if (clr) begin
            mPending = 0;
        end
        if (tset) mTimeout = 1;
        else if (bus.regWr) mTimeout = 0;
    endtask

    task automatic applyStimulus(input bit r, input bit w, input bit sp, input bit idle, input bit turbo);
        @(negedge clk);
        rst = r;
        bus.regWr = w;
        bus.regSpeed = sp;
        bus.busIdle = idle;
        bus.turboSw = turbo;
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic checkOutput(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, ".speed"}, bus.speed, mSpeed);
        checkOutput({tag, ".halt"}, bus.haltReq, mHalt);
        checkOutput({tag, ".busy"}, bus.busy, draining | switching | settling);
        checkOutput({tag, ".chg"}, bus.speedChg, mChg);
        checkOutput({tag, ".timeout"}, bus.timeout, mTimeout);
    endtask

    vec_t vecs[$];
    int pulses;
    bit turbo;
    bit btnOn;

    initial begin
        bus.turboSw = 0;
        bus.regWr = 0;
        bus.regSpeed = 0;
        bus.busIdle = 0;
        modelReset();
`ifdef SPEED_CTRL_TURBO_SW_EN
        btnOn = 1;
`else
        btnOn = 0;
`endif

        // Basic switch to turbo, then a no-op write of the current speed
        vecs.push_back('{1,0,0,1, 0,0,0,0,0});
        vecs.push_back('{0,1,1,1, 0,0,0,0,0});
        vecs.push_back('{0,0,0,1, 0,1,1,0,0});
        vecs.push_back('{0,0,0,1, 0,1,1,0,0});
        vecs.push_back('{0,0,0,1, 0,1,1,0,0});
        vecs.push_back('{0,0,0,1, 1,1,1,1,0});
        vecs.push_back('{0,0,0,1, 1,1,1,0,0});
        vecs.push_back('{0,0,0,1, 1,1,1,0,0});
        vecs.push_back('{0,0,0,1, 1,1,1,0,0});
        vecs.push_back('{0,0,0,1, 1,0,0,0,0});
        vecs.push_back('{0,1,1,0, 1,0,0,0,0});
        vecs.push_back('{0,0,0,0, 1,0,0,0,0});
        vecs.push_back('{0,0,0,0, 1,0,0,0,0});
        vecs.push_back('{1,0,0,0, 0,0,0,0,0});
        vecs.push_back('{0,1,0,1, 0,0,0,0,0});
        vecs.push_back('{0,0,0,1, 0,0,0,0,0});
        vecs.push_back('{0,0,0,1, 0,0,0,0,0});
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].r, vecs[i].w, vecs[i].sp, vecs[i].idle, 1'b0);
            checkOutput($sformatf("vec%0d.speed", i), bus.speed, vecs[i].eSpeed);
            checkOutput($sformatf("vec%0d.halt", i), bus.haltReq, vecs[i].eHalt);
            checkOutput($sformatf("vec%0d.busy", i), bus.busy, vecs[i].eBusy);
            checkOutput($sformatf("vec%0d.chg", i), bus.speedChg, vecs[i].eChg);
            checkOutput($sformatf("vec%0d.timeout", i), bus.timeout, vecs[i].eTmo);
        end

        // Drain timeout with the bus never idle, then a write clears the flag
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        for (int i = 1; i <= DRN + 1; i++) begin
            applyStimulus(0, 0, 0, 0, 0);
            checkModel("tmo");
            checkOutput("tmo.halt", bus.haltReq, (i <= DRN) ? 1'b1 : 1'b0);
            checkOutput("tmo.flag", bus.timeout, (i == DRN + 1) ? 1'b1 : 1'b0);
            checkOutput("tmo.chg", bus.speedChg, 1'b0);
        end
        checkOutput("tmo.speed", bus.speed, 1'b0);
        applyStimulus(0, 1, 0, 1, 0);
        checkOutput("tmo.cleared", bus.timeout, 1'b0);

        // Reset while draining
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("rstDrain.haltBefore", bus.haltReq, 1'b1);
        applyStimulus(1, 0, 0, 1, 0);
        checkOutput("rstDrain.halt", bus.haltReq, 1'b0);
        checkOutput("rstDrain.busy", bus.busy, 1'b0);
        checkOutput("rstDrain.chg", bus.speedChg, 1'b0);
        checkOutput("rstDrain.speed", bus.speed, 1'b0);

        // Reset while settling
        applyStimulus(0, 1, 1, 1, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 0);
        checkOutput("rstSettle.speedBefore", bus.speed, 1'b1);
        checkOutput("rstSettle.busyBefore", bus.busy, 1'b1);
        applyStimulus(1, 0, 0, 1, 0);
        checkOutput("rstSettle.halt", bus.haltReq, 1'b0);
        checkOutput("rstSettle.busy", bus.busy, 1'b0);
        checkOutput("rstSettle.chg", bus.speedChg, 1'b0);
        checkOutput("rstSettle.speed", bus.speed, 1'b0);

        // Bouncing button: one toggle only when the button path is built in
        pulses = 0;
        applyStimulus(1, 0, 0, 1, 0);
        for (int i = 0; i < 45; i++) begin
            turbo = (i < 5) ? ((i % 2) == 0) : 1'b1;
            applyStimulus(0, 0, 0, 1, turbo);
            checkModel("btn");
            if (bus.speedChg === 1'b1) pulses++;
        end
        checkOutput("btn.speed", bus.speed, btnOn);
        checkOutput("btn.onePulse", (pulses == (btnOn ? 1 : 0)), 1'b1);

        // Software write coincident with the debounced rising edge: write wins
        pulses = 0;
        applyStimulus(1, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 0);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(0, (i == 9), 1'b1, 1'b1, 1'b1);
            checkModel("coinc");
            if (bus.speedChg === 1'b1) pulses++;
        end
        checkOutput("coinc.speed", bus.speed, 1'b1);
        checkOutput("coinc.busy", bus.busy, 1'b0);
        checkOutput("coinc.pending", mPending, 1'b0);
        checkOutput("coinc.onePulse", (pulses == 1), 1'b1);

        // Randomized run against the model
        applyStimulus(1, 0, 0, 0, 0);
        turbo = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) turbo = ~turbo;
            applyStimulus($urandom_range(0, 299) == 0,
                          $urandom_range(0, 9) == 0,
                          1'($urandom_range(0, 1)),
                          $urandom_range(0, 9) < 7,
                          turbo);
            checkModel("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/speed_ctrl.md
SPEED_CTRL -- requirements
Module: speed_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 1000000: consecutive stable cycles required to accept a TURBO_SW level.
REQ-002 Parameter SETTLE_CYC, default 16: cycles HALT_REQ stays high after a speed switch.
REQ-003 Parameter DRAIN_TIMEOUT, default 4096: maximum cycles spent waiting for bus idle.
REQ-004 CLK100M  input  1  sole clock; all logic on its rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 TURBO_SW  input  1  asynchronous front-panel turbo button, active-high.
REQ-007 REG_WR  input  1  single-cycle software write strobe.
REQ-008 REG_SPEED  input  1  requested speed on REG_WR (1 = turbo).
REQ-009 BUS_IDLE  input  1  CPU bus idle (no cycle in progress).
REQ-010 SPEED  output  1  registered speed select for the CPU clock generator.
REQ-011 HALT_REQ  output  1  registered request for the CPU to hold off new bus cycles.
REQ-012 BUSY  output  1  high whenever the FSM is not in IDLE.
REQ-013 SPEED_CHG  output  1  one-cycle pulse in the cycle SPEED changes.
REQ-014 TIMEOUT  output  1  sticky flag: last switch attempt was aborted.

Function
REQ-015 TURBO_SW SHALL pass through a 2-flop synchronizer before any other use.
REQ-016 Debounced level SHALL update only after the synchronized input differs from it for DEBOUNCE_CYC consecutive cycles; any bounce restarts the count.
- Rising edge of debounced level toggles TARGET and sets PENDING.
REQ-017 REG_WR SHALL load TARGET <= REG_SPEED and set PENDING.
- Clears TIMEOUT in the same cycle.
REQ-018 REG_WR and a debounced rising edge in the same cycle: REG_WR wins; the button event is dropped.
REQ-019 FSM states: IDLE, DRAIN, SWITCH, SETTLE.
REQ-020 IDLE behaviour:
- PENDING and TARGET != SPEED: go to DRAIN next cycle, HALT_REQ <= 1.
- PENDING and TARGET == SPEED: clear PENDING, stay in IDLE, no pulse.
REQ-021 DRAIN: BUS_IDLE sampled high on 2 consecutive cycles -> SWITCH; a low sample restarts the pair.
REQ-022 SWITCH (exactly 1 cycle):
- SPEED <= TARGET, SPEED_CHG = 1, PENDING cleared, go to SETTLE.
REQ-023 SETTLE: hold HALT_REQ high for SETTLE_CYC cycles, then IDLE with HALT_REQ <= 0.
REQ-024 DRAIN_TIMEOUT consecutive cycles in DRAIN without reaching SWITCH:
- Go to IDLE, HALT_REQ <= 0, TIMEOUT <= 1, PENDING cleared, SPEED unchanged.
REQ-025 Requests arriving outside IDLE SHALL update TARGET/PENDING (latest wins).
- Serviced on the next IDLE cycle.
- TARGET latched at SWITCH is what is applied.
REQ-026 SPEED SHALL never change outside SWITCH.
- SPEED_CHG SHALL never assert without a SPEED change.
REQ-027 Counter widths SHALL be sized from the parameters (clog2).
- Counters saturate, never wrap.

Reset
REQ-028 RESET SHALL force, on the next clock edge:
- State = IDLE; SPEED, HALT_REQ, BUSY, SPEED_CHG, TIMEOUT, PENDING = 0; TARGET = 0.
- All counters and the debounced level = 0.
REQ-029 RESET mid-operation (any state) SHALL abort without a SPEED_CHG pulse; HALT_REQ drops on that edge.

Configuration
REQ-030 Macro SPEED_CTRL_TURBO_SW_EN:
- Defined: button path (REQ-015/016) present.
- Undefined: TURBO_SW ignored, no synchronizer/debounce logic; speed changes only via REG_WR.

Verification (DEBOUNCE_CYC=8, SETTLE_CYC=4, DRAIN_TIMEOUT=20)
REQ-031 Reset, REG_WR with REG_SPEED=1, BUS_IDLE=1 -> HALT_REQ high 1 cycle later; SPEED=1 with SPEED_CHG pulse 3 cycles after HALT_REQ rises; HALT_REQ low 4 cycles after SWITCH.
REQ-032 REG_WR REG_SPEED=1, BUS_IDLE=0 for 20 cycles -> TIMEOUT=1, SPEED=0, HALT_REQ=0, no SPEED_CHG; next REG_WR clears TIMEOUT.
REQ-033 TURBO_SW bounces for 5 cycles then high for 8 -> exactly one toggle; SPEED goes 0 to 1 once (macro defined); with macro undefined, SPEED stays 0.
REQ-034 REG_WR REG_SPEED=1 in the same cycle as a debounced button edge, SPEED=0 -> one switch to 1, then IDLE with PENDING=0.
REQ-035 RESET asserted during SETTLE and during DRAIN -> IDLE, HALT_REQ=0, no SPEED_CHG; SPEED=0 after reset.
REQ-036 REG_WR REG_SPEED=0 while SPEED=0 -> no HALT_REQ, BUSY stays 0.
